// File: rtl/video_win_pkg.sv
// Shared types and constants for the video output window calculator.
//   state_e     : sequencing states of the window FSM
//   req_t       : one snapshot of the raster size and AR request
//   DIV_CYCLES  : iteration count of the 24/12 restoring divider
//   LAT_*       : input-change to WIN_VALID latency for each request class
package video_win_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LATCH,
      DIV_W,
      CMP,
      DIV_H,
      CENTER
   } state_e;

   typedef struct packed {
      logic [11:0] w;
      logic [11:0] h;
      logic [12:0] arx;
      logic [12:0] ary;
   } req_t;

   localparam int unsigned DIV_CYCLES = 24;

   localparam int unsigned LAT_DIRECT = 3;
   localparam int unsigned LAT_HFIT   = 29;
   localparam int unsigned LAT_WFIT   = 54;

   function automatic logic [11:0] min12(input logic [11:0] a, input logic [11:0] b);
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/video_win_div.sv
// 24/12 unsigned restoring divider, one quotient bit per cycle.
//   clk, rst : clock and synchronous active-high reset (clears all state)
//   start    : load num/den; may restart a divide that is still running
//   busy     : high while iterations remain
//   num, den : dividend (24 bit) and divisor (12 bit, never zero)
//   quot     : quotient, saturated to 4095; valid once busy has dropped
module video_win_div
   import video_win_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        busy,
   input  logic [23:0] num,
   input  logic [11:0] den,
   output logic [11:0] quot
);

   logic [4:0]  cnt_q, cnt_d;
   logic [11:0] rem_q, rem_d;
   logic [11:0] den_q, den_d;
   logic [23:0] sh_q, sh_d;
   logic [12:0] trial;

   // sh_q shifts dividend bits out of the top while quotient bits enter at
   // the bottom; after DIV_CYCLES steps it holds the full 24-bit quotient.
   always_comb begin
      cnt_d = cnt_q;
      rem_d = rem_q;
      den_d = den_q;
      sh_d  = sh_q;
      trial = {rem_q, sh_q[23]};
      if (start) begin
         cnt_d = 5'(DIV_CYCLES);
         rem_d = '0;
         den_d = den;
         sh_d  = num;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 5'd1;
         if (trial >= {1'b0, den_q}) begin
            rem_d = 12'(trial - {1'b0, den_q});
            sh_d  = {sh_q[22:0], 1'b1};
         end else begin
            rem_d = trial[11:0];
            sh_d  = {sh_q[22:0], 1'b0};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         rem_q <= '0;
         den_q <= '0;
         sh_q  <= '0;
      end else begin
         cnt_q <= cnt_d;
         rem_q <= rem_d;
         den_q <= den_d;
         sh_q  <= sh_d;
      end
   end

   assign busy = (cnt_q != '0);
   assign quot = (|sh_q[23:12]) ? '1 : sh_q[11:0];

endmodule

// File: rtl/video_window_calc.sv
// Converts the crop/integer-scale AR request into a centred output window.
//   CLK_VIDEO, RESET        : video clock, synchronous active-high reset
//   HDMI_WIDTH/HDMI_HEIGHT  : active raster size W x H
//   ARX/ARY                 : bit 12 set on ARX = literal size, else aspect
//                             ratio; a zero low field on either = full raster
//   WIN_HMIN/HMAX/VMIN/VMAX : inclusive window bounds, updated together
//   WIN_VALID               : window matches the current inputs
module video_window_calc
   import video_win_pkg::*;
(
   input  logic        CLK_VIDEO,
   input  logic        RESET,
   input  logic [11:0] HDMI_WIDTH,
   input  logic [11:0] HDMI_HEIGHT,
   input  logic [12:0] ARX,
   input  logic [12:0] ARY,
   output logic [11:0] WIN_HMIN,
   output logic [11:0] WIN_HMAX,
   output logic [11:0] WIN_VMIN,
   output logic [11:0] WIN_VMAX,
   output logic        WIN_VALID
);

   state_e      state_q, state_d;
   req_t        in_q, in_d;
   req_t        lat_q, lat_d;
   logic        in_rst_q, in_rst_d;
   logic        pend_q, pend_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [11:0] w_q, w_d;
   logic [11:0] h_q, h_d;
   logic        hdiv_q, hdiv_d;
   logic [11:0] hmin_q, hmin_d;
   logic [11:0] hmax_q, hmax_d;
   logic [11:0] vmin_q, vmin_d;
   logic [11:0] vmax_q, vmax_d;
   logic        valid_q, valid_d;

   logic        change;
   logic        div_start, div_busy, div_last;
   logic [11:0] mul_a, mul_b, div_den, div_quot;
   logic [23:0] product;
   logic [11:0] w_eff, h_eff, hmin_c, vmin_c;

   // One multiplier serves both divides: DIV_W needs H*ARX/ARY, DIV_H W*ARY/ARX.
   always_comb begin
      mul_a   = lat_q.h;
      mul_b   = lat_q.arx[11:0];
      div_den = lat_q.ary[11:0];
      if (state_q == DIV_H) begin
         mul_a   = lat_q.w;
         mul_b   = lat_q.ary[11:0];
         div_den = lat_q.arx[11:0];
      end
      product = {12'd0, mul_a} * {12'd0, mul_b};
   end

   assign change    = (in_q != lat_q) || pend_q;
   assign div_start = ((state_q == DIV_W) || (state_q == DIV_H)) && (cnt_q == '0);
   // cnt_q == DIV_CYCLES is the cycle of the divider's final iteration
   assign div_last  = (cnt_q == 5'(DIV_CYCLES)) && div_busy;

   video_win_div u_div (
      .clk   (CLK_VIDEO),
      .rst   (RESET),
      .start (div_start),
      .busy  (div_busy),
      .num   (product),
      .den   (div_den),
      .quot  (div_quot)
   );

   // Centring datapath. On the width-fit path the height comes straight
   // from the divider, whose quotient settles on entry to CENTER.
   always_comb begin
      h_eff  = hdiv_q ? min12(div_quot, lat_q.h) : h_q;
      if (h_eff == '0) h_eff = 12'd1;
      w_eff  = (w_q == '0) ? 12'd1 : w_q;
      hmin_c = (lat_q.w - w_eff) >> 1;
      vmin_c = (lat_q.h - h_eff) >> 1;
   end

   always_comb begin
      in_d     = '{w: HDMI_WIDTH, h: HDMI_HEIGHT, arx: ARX, ary: ARY};
      state_d  = state_q;
      lat_d    = lat_q;
      in_rst_d = 1'b0;
      pend_d   = pend_q;
      cnt_d    = cnt_q;
      w_d      = w_q;
      h_d      = h_q;
      hdiv_d   = hdiv_q;
      hmin_d   = hmin_q;
      hmax_d   = hmax_q;
      vmin_d   = vmin_q;
      vmax_d   = vmax_q;
      valid_d  = valid_q;

      if ((state_q != IDLE) && (state_q != LATCH) && change) begin
         state_d = LATCH;
         valid_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (change) begin
                  state_d = LATCH;
                  valid_d = 1'b0;
               end
            end
            LATCH: begin
               lat_d   = in_q;
               pend_d  = 1'b0;
               cnt_d   = '0;
               hdiv_d  = 1'b0;
               state_d = CENTER;
               if ((in_q.arx[11:0] == '0) || (in_q.ary[11:0] == '0)) begin
                  w_d = in_q.w;
                  h_d = in_q.h;
               end else if (in_q.arx[12]) begin
                  w_d = min12(in_q.arx[11:0], in_q.w);
                  h_d = min12(in_q.ary[11:0], in_q.h);
               end else if ((in_q.w != '0) && (in_q.h != '0)) begin
                  state_d = DIV_W;
               end
            end
            DIV_W: begin
               cnt_d = cnt_q + 5'd1;
               if (div_last) begin
                  cnt_d   = '0;
                  state_d = CMP;
               end
            end
            CMP: begin
               if (div_quot <= lat_q.w) begin
                  w_d     = div_quot;
                  h_d     = lat_q.h;
                  state_d = CENTER;
               end else begin
                  w_d     = lat_q.w;
                  hdiv_d  = 1'b1;
                  cnt_d   = '0;
                  state_d = DIV_H;
               end
            end
            DIV_H: begin
               cnt_d = cnt_q + 5'd1;
               if (div_last) begin
                  cnt_d   = '0;
                  state_d = CENTER;
               end
            end
            CENTER: begin
               if ((lat_q.w == '0) || (lat_q.h == '0)) begin
                  hmin_d = '0;
                  hmax_d = '0;
                  vmin_d = '0;
                  vmax_d = '0;
               end else begin
                  hmin_d = hmin_c;
                  hmax_d = hmin_c + w_eff - 12'd1;
                  vmin_d = vmin_c;
                  vmax_d = vmin_c + h_eff - 12'd1;
               end
               valid_d = 1'b1;
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end

      // Release of RESET is treated as an input change one cycle later,
      // so the first computation has the same latency as any other.
      if (in_rst_q) pend_d = 1'b1;
   end

   always_ff @(posedge CLK_VIDEO) begin
      if (RESET) begin
         state_q  <= IDLE;
         in_q     <= '0;
         lat_q    <= '0;
         in_rst_q <= 1'b1;
         pend_q   <= 1'b0;
         cnt_q    <= '0;
         w_q      <= '0;
         h_q      <= '0;
         hdiv_q   <= 1'b0;
         hmin_q   <= '0;
         hmax_q   <= '0;
         vmin_q   <= '0;
         vmax_q   <= '0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         in_q     <= in_d;
         lat_q    <= lat_d;
         in_rst_q <= in_rst_d;
         pend_q   <= pend_d;
         cnt_q    <= cnt_d;
         w_q      <= w_d;
         h_q      <= h_d;
         hdiv_q   <= hdiv_d;
         hmin_q   <= hmin_d;
         hmax_q   <= hmax_d;
         vmin_q   <= vmin_d;
         vmax_q   <= vmax_d;
         valid_q  <= valid_d;
      end
   end

   assign WIN_HMIN  = hmin_q;
   assign WIN_HMAX  = hmax_q;
   assign WIN_VMIN  = vmin_q;
   assign WIN_VMAX  = vmax_q;
   assign WIN_VALID = valid_q;

endmodule

// File: tb/tb_video_window_calc.sv
module tb_video_window_calc;
   import video_win_pkg::*;

   logic        CLK_VIDEO = 1'b0;
   logic        RESET     = 1'b1;
   logic [11:0] HDMI_WIDTH  = '0;
   logic [11:0] HDMI_HEIGHT = '0;
   logic [12:0] ARX = '0;
   logic [12:0] ARY = '0;
   logic [11:0] WIN_HMIN, WIN_HMAX, WIN_VMIN, WIN_VMAX;
   logic        WIN_VALID;

   int checks = 0;
   int errors = 0;

   video_window_calc dut (
      .CLK_VIDEO   (CLK_VIDEO),
      .RESET       (RESET),
      .HDMI_WIDTH  (HDMI_WIDTH),
      .HDMI_HEIGHT (HDMI_HEIGHT),
      .ARX         (ARX),
      .ARY         (ARY),
      .WIN_HMIN    (WIN_HMIN),
      .WIN_HMAX    (WIN_HMAX),
      .WIN_VMIN    (WIN_VMIN),
      .WIN_VMAX    (WIN_VMAX),
      .WIN_VALID   (WIN_VALID)
   );

   always #5 CLK_VIDEO = ~CLK_VIDEO;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Reference: window from the raster and request using integer arithmetic.
   function automatic void model(input logic [11:0] wi, input logic [11:0] hi,
                                 input logic [12:0] xi, input logic [12:0] yi,
                                 output logic [47:0] win, output int lat);
      int unsigned W, H, ax, ay, w, h, q, hmn, vmn;
      W = wi; H = hi; ax = xi[11:0]; ay = yi[11:0];
      lat = LAT_DIRECT;
      if (W == 0 || H == 0) begin
         win = '0;
         return;
      end
      if (ax == 0 || ay == 0) begin
         w = W; h = H;
      end else if (xi[12]) begin
         w = (ax < W) ? ax : W;
         h = (ay < H) ? ay : H;
      end else begin
         q = (H * ax) / ay;
         if (q > 4095) q = 4095;
         if (q <= W) begin
            w = q; h = H; lat = LAT_HFIT;
         end else begin
            w = W;
            q = (W * ay) / ax;
            if (q > 4095) q = 4095;
            h = (q < H) ? q : H;
            lat = LAT_WFIT;
         end
      end
      if (w == 0) w = 1;
      if (h == 0) h = 1;
      hmn = (W - w) / 2;
      vmn = (H - h) / 2;
      win = {12'(hmn), 12'(hmn + w - 1), 12'(vmn), 12'(vmn + h - 1)};
   endfunction

   task automatic apply(input logic [11:0] w, input logic [11:0] h,
                        input logic [12:0] x, input logic [12:0] y);
      @(negedge CLK_VIDEO);
      HDMI_WIDTH = w; HDMI_HEIGHT = h; ARX = x; ARY = y;
   endtask

   // Measures edges from the sampling edge of the last input change until
   // WIN_VALID rises; notes whether the outputs moved while it was low.
   task automatic measure(input int budget, output int lat, output bit held,
                          output logic [47:0] win);
      logic [47:0] old;
      lat  = -1;
      held = 1'b1;
      @(posedge CLK_VIDEO); #1;
      old = {WIN_HMIN, WIN_HMAX, WIN_VMIN, WIN_VMAX};
      for (int k = 1; k <= budget; k++) begin
         @(posedge CLK_VIDEO); #1;
         if (WIN_VALID === 1'b1) begin
            lat = k;
            break;
         end
         if ({WIN_HMIN, WIN_HMAX, WIN_VMIN, WIN_VMAX} !== old) held = 1'b0;
      end
      win = {WIN_HMIN, WIN_HMAX, WIN_VMIN, WIN_VMAX};
   endtask

   task automatic test_reset();
      int lat; bit held; logic [47:0] win;
      RESET = 1'b1;
      HDMI_WIDTH = 12'd1920; HDMI_HEIGHT = 12'd1080; ARX = 13'd4; ARY = 13'd3;
      repeat (3) @(posedge CLK_VIDEO);
      #1;
      checks++;
      if ({WIN_HMIN, WIN_HMAX, WIN_VMIN, WIN_VMAX, WIN_VALID} !== 49'd0) begin
         errors++;
         $display("FAIL reset_state: got %h expected 0",
                  {WIN_HMIN, WIN_HMAX, WIN_VMIN, WIN_VMAX, WIN_VALID});
      end
      @(negedge CLK_VIDEO);
      RESET = 1'b0;
      measure(80, lat, held, win);
      checks++;
      if (lat != 29) begin
         errors++;
         $display("FAIL reset_release_latency: got %0d expected 29", lat);
      end
      checks++;
      if (win !== {12'd240, 12'd1679, 12'd0, 12'd1079}) begin
         errors++;
         $display("FAIL reset_release_window: got %0d/%0d/%0d/%0d expected 240/1679/0/1079",
                  win[47:36], win[35:24], win[23:12], win[11:0]);
      end
   endtask

   task automatic test_directed(input string name, input logic [11:0] w, input logic [11:0] h,
                                input logic [12:0] x, input logic [12:0] y,
                                input logic [47:0] exp_win, input int exp_lat);
      int lat; bit held; logic [47:0] win;
      apply(w, h, x, y);
      measure(80, lat, held, win);
      checks++;
      if (lat != exp_lat) begin
         errors++;
         $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
      end
      checks++;
      if (win !== exp_win) begin
         errors++;
         $display("FAIL %s window: got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d", name,
                  win[47:36], win[35:24], win[23:12], win[11:0],
                  exp_win[47:36], exp_win[35:24], exp_win[23:12], exp_win[11:0]);
      end
      checks++;
      if (!held) begin
         errors++;
         $display("FAIL %s hold: outputs moved got 0 expected 1", name);
      end
   endtask

   task automatic test_abort();
      int lat; bit held, early_ok; logic [47:0] win, old;
      apply(12'd1920, 12'd1080, 13'd0, 13'd7);
      measure(80, lat, held, old);
      checks++;
      if (old !== {12'd0, 12'd1919, 12'd0, 12'd1079}) begin
         errors++;
         $display("FAIL abort_setup window: got %h expected full raster", old);
      end
      apply(12'd1920, 12'd1080, 13'd4, 13'd3);
      early_ok = 1'b1;
      @(posedge CLK_VIDEO);
      for (int k = 1; k <= 11; k++) begin
         @(posedge CLK_VIDEO); #1;
         if (WIN_VALID !== 1'b0 || {WIN_HMIN, WIN_HMAX, WIN_VMIN, WIN_VMAX} !== old)
            early_ok = 1'b0;
      end
      apply(12'd1920, 12'd1080, 13'd4, 13'd4);
      measure(80, lat, held, win);
      checks++;
      if (!early_ok || !held) begin
         errors++;
         $display("FAIL abort_hold: got early=%0d held=%0d expected 1/1", early_ok, held);
      end
      checks++;
      if (lat != 29) begin
         errors++;
         $display("FAIL abort_latency: got %0d expected 29", lat);
      end
      checks++;
      if (win !== {12'd420, 12'd1499, 12'd0, 12'd1079}) begin
         errors++;
         $display("FAIL abort_window: got %0d/%0d/%0d/%0d expected 420/1499/0/1079",
                  win[47:36], win[35:24], win[23:12], win[11:0]);
      end
   endtask

   task automatic test_reset_mid_div();
      int lat; bit held; logic [47:0] win;
      apply(12'd1920, 12'd1080, 13'd32, 13'd9);
      repeat (40) @(posedge CLK_VIDEO);
      @(negedge CLK_VIDEO);
      RESET = 1'b1; ARX = 13'd4; ARY = 13'd3;
      @(posedge CLK_VIDEO); #1;
      checks++;
      if ({WIN_HMIN, WIN_HMAX, WIN_VMIN, WIN_VMAX, WIN_VALID} !== 49'd0) begin
         errors++;
         $display("FAIL reset_mid_div state: got %h expected 0",
                  {WIN_HMIN, WIN_HMAX, WIN_VMIN, WIN_VMAX, WIN_VALID});
      end
      repeat (2) @(posedge CLK_VIDEO);
      @(negedge CLK_VIDEO);
      RESET = 1'b0;
      measure(80, lat, held, win);
      checks++;
      if (lat != 29) begin
         errors++;
         $display("FAIL reset_mid_div latency: got %0d expected 29", lat);
      end
      checks++;
      if (win !== {12'd240, 12'd1679, 12'd0, 12'd1079}) begin
         errors++;
         $display("FAIL reset_mid_div window: got %0d/%0d/%0d/%0d expected 240/1679/0/1079",
                  win[47:36], win[35:24], win[23:12], win[11:0]);
      end
   endtask

   task automatic gen_req(output logic [11:0] w, output logic [11:0] h,
                          output logic [12:0] x, output logic [12:0] y);
      int unsigned mode;
      w = ($urandom_range(0, 15) == 0) ? 12'd0 : 12'($urandom_range(1, 4095));
      h = ($urandom_range(0, 15) == 0) ? 12'd0 : 12'($urandom_range(1, 4095));
      mode = $urandom_range(0, 3);
      case (mode)
         0: begin
            x = {1'($urandom), 12'd0};
            y = 13'($urandom);
            if ($urandom_range(0, 1) == 1) begin
               x = 13'($urandom); y = {1'($urandom), 12'd0};
            end
         end
         1: begin
            x = {1'b1, 12'($urandom_range(1, 4095))};
            y = {1'($urandom), 12'($urandom_range(1, 4095))};
         end
         2: begin
            x = {1'b0, 12'($urandom_range(1, 64))};
            y = {1'($urandom), 12'($urandom_range(1, 64))};
         end
         default: begin
            x = {1'b0, 12'($urandom_range(1, 4095))};
            y = {1'($urandom), 12'($urandom_range(1, 4095))};
         end
      endcase
   endtask

   task automatic test_random(input int n);
      int lat, exp_lat; bit held; logic [47:0] win, exp_win;
      logic [11:0] w, h; logic [12:0] x, y;
      for (int i = 0; i < n; i++) begin
         do gen_req(w, h, x, y);
         while ({w, h, x, y} == {HDMI_WIDTH, HDMI_HEIGHT, ARX, ARY});
         model(w, h, x, y, exp_win, exp_lat);
         apply(w, h, x, y);
         measure(80, lat, held, win);
         checks++;
         if (lat != exp_lat || !held) begin
            errors++;
            $display("FAIL random[%0d] latency: got %0d held=%0d expected %0d (W=%0d H=%0d X=%h Y=%h)",
                     i, lat, held, exp_lat, w, h, x, y);
         end
         checks++;
         if (win !== exp_win) begin
            errors++;
            $display("FAIL random[%0d] window: got %h expected %h (W=%0d H=%0d X=%h Y=%h)",
                     i, win, exp_win, w, h, x, y);
         end
      end
   endtask

   task automatic test_back_to_back(input int n);
      int lat, exp_lat, gap; bit held; logic [47:0] win, exp_win;
      logic [11:0] w, h; logic [12:0] x, y;
      for (int i = 0; i < n; i++) begin
         do gen_req(w, h, x, y);
         while ({w, h, x, y} == {HDMI_WIDTH, HDMI_HEIGHT, ARX, ARY});
         apply(w, h, x, y);
         gap = $urandom_range(2, 60);
         repeat (gap - 1) @(negedge CLK_VIDEO);
         do gen_req(w, h, x, y);
         while ({w, h, x, y} == {HDMI_WIDTH, HDMI_HEIGHT, ARX, ARY});
         model(w, h, x, y, exp_win, exp_lat);
         apply(w, h, x, y);
         measure(80, lat, held, win);
         checks++;
         if (lat != exp_lat || !held) begin
            errors++;
            $display("FAIL b2b[%0d] gap %0d latency: got %0d held=%0d expected %0d",
                     i, gap, lat, held, exp_lat);
         end
         checks++;
         if (win !== exp_win) begin
            errors++;
            $display("FAIL b2b[%0d] gap %0d window: got %h expected %h", i, gap, win, exp_win);
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed("full_arx0", 12'd1920, 12'd1080, 13'd0, 13'd3,
                    {12'd0, 12'd1919, 12'd0, 12'd1079}, 3);
      test_directed("height_fit", 12'd1920, 12'd1080, 13'd4, 13'd3,
                    {12'd240, 12'd1679, 12'd0, 12'd1079}, 29);
      test_directed("width_fit", 12'd1920, 12'd1080, 13'd32, 13'd9,
                    {12'd0, 12'd1919, 12'd270, 12'd809}, 54);
      test_directed("literal", 12'd1920, 12'd1080, 13'h1500, 13'h13C0,
                    {12'd320, 12'd1599, 12'd60, 12'd1019}, 3);
      test_directed("literal_oversize", 12'd1920, 12'd1080, 13'h17D0, 13'h13C0,
                    {12'd0, 12'd1919, 12'd60, 12'd1019}, 3);
      test_directed("full_ary0", 12'd1920, 12'd1080, 13'd16, 13'h1000,
                    {12'd0, 12'd1919, 12'd0, 12'd1079}, 3);
      test_directed("degenerate", 12'd0, 12'd1080, 13'd4, 13'd3, 48'd0, 3);
      test_abort();
      test_reset_mid_div();
      test_random(30);
      test_back_to_back(10);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
